port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of upstream input buffers arbitrated.
REQ-002 SHALL have parameter FLIT_W, default 64, flit width; bit FLIT_W-1 = head flag, bit FLIT_W-2 = tail flag.
REQ-003 SHALL have parameter CREDITS, default 7, initial credit count; equals downstream buffer depth minus 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_flit  input  NUM_IN*FLIT_W  show-ahead heads of input buffers; slice i = buffer i.
REQ-007 SHALL have port in_empty  input  NUM_IN  per-buffer empty flag.
REQ-008 SHALL have port in_consume  output  NUM_IN  one-hot-or-zero pop strobe to input buffers, combinational.
REQ-009 SHALL have port out_flit  output  FLIT_W  registered flit to downstream buffer write data.
REQ-010 SHALL have port out_produce  output  1  registered write strobe to downstream buffer.
REQ-011 SHALL have port credit_in  input  1  one-cycle pulse; downstream popped one flit.
REQ-012 SHALL have port credit_cnt  output  $clog2(CREDITS+1)  current credits available.

Function
REQ-013 SHALL implement FSM with states IDLE (no packet owned) and LOCKED (wormhole, input owner holds port).
REQ-014 In IDLE, SHALL grant round-robin among inputs with ~in_empty[i] and head flag set, starting search at rr_ptr.
REQ-015 Flit SHALL be sent in a cycle only if credit_cnt > 0; send = assert in_consume[sel] and register flit for next cycle.
REQ-016 Grant of a head flit without tail SHALL move IDLE->LOCKED with owner = granted index; rr_ptr <= owner+1 mod NUM_IN.
REQ-017 Head flit with tail set (single-flit packet) SHALL stay in IDLE and advance rr_ptr.
REQ-018 In LOCKED, SHALL send only from owner; others ignored even if non-empty.
REQ-019 Sending owner flit with tail flag SHALL return to IDLE in the next cycle.
REQ-020 Non-head flit at an input head in IDLE SHALL be ignored (never granted); no pop.
REQ-021 Latency: in_consume at cycle N -> out_produce=1 with that flit at cycle N+1.
REQ-022 out_produce SHALL be 0 in any cycle following a no-send cycle; out_flit holds last value.
REQ-023 credit_cnt SHALL decrement on send, increment on credit_in, unchanged when both occur same cycle.
REQ-024 credit_in when credit_cnt==CREDITS and no send SHALL be ignored (saturate, no wrap).
REQ-025 credit_cnt==0 SHALL stall: in_consume all 0, FSM state and owner unchanged.
REQ-026 Owner empty in LOCKED SHALL stall without leaving LOCKED.
REQ-027 Throughput SHALL be one flit per cycle when credits and data are available.

Reset
REQ-028 On rst low, asynchronously: state=IDLE, rr_ptr=0, owner=0, credit_cnt=CREDITS, out_produce=0, out_flit=0.
REQ-029 Reset mid-packet SHALL abandon the packet; no partial recovery; in_consume=0 while rst low.

Structure
REQ-030 Shared package router_pkg SHALL hold state enum (IDLE, LOCKED) and HEAD_BIT/TAIL_BIT position functions of FLIT_W.
REQ-031 Round-robin pick SHALL be sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).
REQ-032 No storage beyond the output register; buffering stays in upstream/downstream buffers.

Verification
REQ-033 Single-flit packets on inputs 0 and 2 simultaneously, CREDITS=7 -> grant 0 at cycle 1, 2 at cycle 2, out_produce high cycles 2-3.
REQ-034 3-flit packet on input 1, head on input 3 concurrent -> flits 1a,1b,1c contiguous, then 3 head; in_consume[3]=0 until tail sent.
REQ-035 No credit_in, 10 flits queued -> exactly 7 sent, credit_cnt=0, stall; one credit_in pulse -> one more flit.
REQ-036 credit_in and send same cycle at credit_cnt=3 -> credit_cnt stays 3.
REQ-037 rst low during flit 2 of 4-flit packet -> outputs to reset values asynchronously, credit_cnt=7, state IDLE after release.
REQ-038 Body flit (head=0) alone at input 0 in IDLE -> never consumed, out_produce stays 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: arbiter FSM states and flit control-bit positions.
package router_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned head_bit(input int unsigned flit_w);
    return flit_w - 1;
  endfunction

  function automatic int unsigned tail_bit(input int unsigned flit_w);
    return flit_w - 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt_c,
  output logic [IDXW-1:0] idx_c,
  output logic            valid_c
);

  int unsigned k;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(ptr) + i) % N;
      if (!valid_c && req[k]) begin
        valid_c  = 1'b1;
        gnt_c[k] = 1'b1;
        idx_c    = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Wormhole output-port arbiter: round-robin packet grant, credit flow control,
// one registered flit per cycle to the downstream buffer.
module port_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned FLIT_W  = 64,
  parameter int unsigned CREDITS = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN*FLIT_W-1:0]       in_flit,
  input  logic [NUM_IN-1:0]              in_empty,
  output logic [NUM_IN-1:0]              in_consume,
  output logic [FLIT_W-1:0]              out_flit,
  output logic                           out_produce,
  input  logic                           credit_in,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt
);

  localparam int unsigned IDXW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CW   = $clog2(CREDITS + 1);
  localparam int unsigned HB   = head_bit(FLIT_W);
  localparam int unsigned TB   = tail_bit(FLIT_W);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              produce_q, produce_d;

  logic [FLIT_W-1:0] flits [NUM_IN];
  logic [NUM_IN-1:0] head_req;
  logic [NUM_IN-1:0] arb_gnt;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_valid;
  logic [IDXW-1:0]   sel;
  logic              sel_valid;
  logic              send;
  logic [FLIT_W-1:0] sel_flit;

  // Only non-empty inputs presenting a head flit may win a new packet.
  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flits[i]    = in_flit[i*FLIT_W +: FLIT_W];
      head_req[i] = ~in_empty[i] & flits[i][HB];
    end
  end

  rr_arbiter #(.N(NUM_IN), .IDXW(IDXW)) u_rr (
    .req     (head_req),
    .ptr     (rr_q),
    .gnt_c   (arb_gnt),
    .idx_c   (arb_idx),
    .valid_c (arb_valid)
  );

  always_comb begin
    if (state_q == LOCKED) begin
      sel       = owner_q;
      sel_valid = ~in_empty[owner_q];
    end else begin
      sel       = arb_idx;
      sel_valid = arb_valid;
    end
    sel_flit = flits[sel];
    send     = rst & sel_valid & (credit_q != '0);
    in_consume = '0;
    if (send) in_consume[sel] = 1'b1;
  end

  // Next-state: FSM, pointer, credits, output register.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    credit_d   = credit_q;
    out_flit_d = out_flit_q;
    produce_d  = send;

    if (send) begin
      out_flit_d = sel_flit;
      if (state_q == IDLE) begin
        rr_d = (32'(sel) == NUM_IN - 1) ? '0 : sel + IDXW'(1);
        if (!sel_flit[TB]) begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end else if (sel_flit[TB]) begin
        state_d = IDLE;
      end
    end

    case ({send, credit_in})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   if (credit_q != CW'(CREDITS)) credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_q       <= '0;
      credit_q   <= CW'(CREDITS);
      out_flit_q <= '0;
      produce_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      credit_q   <= credit_d;
      out_flit_q <= out_flit_d;
      produce_q  <= produce_d;
    end
  end

  assign out_flit    = out_flit_q;
  assign out_produce = produce_q;
  assign credit_cnt  = credit_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: bench-side input queues, hand-computed expectations.
module tb_port_arbiter;

  localparam int unsigned NUM_IN  = 4;
  localparam int unsigned FLIT_W  = 64;
  localparam int unsigned CREDITS = 7;

  logic                     clk;
  logic                     rst;
  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_empty;
  logic [NUM_IN-1:0]        in_consume;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_produce;
  logic                     credit_in;
  logic [2:0]               credit_cnt;

  port_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit     (in_flit),
    .in_empty    (in_empty),
    .in_consume  (in_consume),
    .out_flit    (out_flit),
    .out_produce (out_produce),
    .credit_in   (credit_in),
    .credit_cnt  (credit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [FLIT_W-1:0] q [NUM_IN][$];
  logic [NUM_IN-1:0] last_cons;
  int                errors = 0;
  int                checks = 0;
  int                sent;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic h, input logic t, input int p);
    return {h, t, 62'(p)};
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_IN; i++) begin
      in_empty[i] = (q[i].size() == 0);
      in_flit[i*FLIT_W +: FLIT_W] = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // One clock: pops what the DUT consumes on this edge, then re-presents heads.
  task automatic tick();
    last_cons = in_consume;
    @(posedge clk);
    #1;
    credit_in = 1'b0;
    for (int i = 0; i < NUM_IN; i++)
      if (last_cons[i] && q[i].size() != 0) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic push(input int i, input logic [FLIT_W-1:0] f);
    q[i].push_back(f);
    drive();
    #1;
  endtask

  task automatic credit_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      credit_in = 1'b1;
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    credit_in = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_produce", 64'(out_produce), 64'd0);
    check_eq("rst_flit", out_flit, 64'd0);
    check_eq("rst_credit", 64'(credit_cnt), 64'd7);
    check_eq("rst_consume", 64'(in_consume), 64'd0);
    rst = 1'b1;
    tick();

    // Two single-flit packets on 0 and 2
    push(0, mk(1, 1, 'h100));
    push(2, mk(1, 1, 'h200));
    check_eq("rr_c1_consume", 64'(in_consume), 64'b0001);
    tick();
    check_eq("rr_c2_produce", 64'(out_produce), 64'd1);
    check_eq("rr_c2_flit", out_flit, mk(1, 1, 'h100));
    check_eq("rr_c2_consume", 64'(in_consume), 64'b0100);
    tick();
    check_eq("rr_c3_produce", 64'(out_produce), 64'd1);
    check_eq("rr_c3_flit", out_flit, mk(1, 1, 'h200));
    check_eq("rr_c3_consume", 64'(in_consume), 64'd0);
    tick();
    check_eq("rr_c4_produce", 64'(out_produce), 64'd0);
    check_eq("rr_c4_hold", out_flit, mk(1, 1, 'h200));
    check_eq("rr_credit", 64'(credit_cnt), 64'd5);
    credit_pulses(2);
    check_eq("rr_credit_back", 64'(credit_cnt), 64'd7);

    // Wormhole: 3-flit packet on 1 holds the port against a head on 3
    push(1, mk(1, 0, 'h1a));
    push(1, mk(0, 0, 'h1b));
    push(1, mk(0, 1, 'h1c));
    check_eq("wh_1a_consume", 64'(in_consume), 64'b0010);
    tick();
    push(3, mk(1, 1, 'h300));
    check_eq("wh_1a_out", out_flit, mk(1, 0, 'h1a));
    check_eq("wh_1b_consume", 64'(in_consume), 64'b0010);
    tick();
    check_eq("wh_1b_out", out_flit, mk(0, 0, 'h1b));
    check_eq("wh_1c_consume", 64'(in_consume), 64'b0010);
    tick();
    check_eq("wh_1c_out", out_flit, mk(0, 1, 'h1c));
    check_eq("wh_3_consume", 64'(in_consume), 64'b1000);
    tick();
    check_eq("wh_3_out", out_flit, mk(1, 1, 'h300));
    check_eq("wh_3_produce", 64'(out_produce), 64'd1);
    check_eq("wh_credit", 64'(credit_cnt), 64'd3);

    // Send and credit return in the same cycle leave the count unchanged
    push(0, mk(1, 1, 'h0a0));
    credit_in = 1'b1;
    check_eq("both_consume", 64'(in_consume), 64'b0001);
    tick();
    check_eq("both_credit", 64'(credit_cnt), 64'd3);
    check_eq("both_produce", 64'(out_produce), 64'd1);
    credit_pulses(4);
    check_eq("both_credit_back", 64'(credit_cnt), 64'd7);

    // Credit exhaustion with ten queued packets
    for (int k = 0; k < 10; k++) q[0].push_back(mk(1, 1, 'h500 + k));
    drive();
    #1;
    sent = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (last_cons[0]) sent++;
    end
    check_eq("cr_sent", 64'(sent), 64'd7);
    check_eq("cr_zero", 64'(credit_cnt), 64'd0);
    check_eq("cr_stall", 64'(in_consume), 64'd0);
    check_eq("cr_left", 64'(q[0].size()), 64'd3);
    credit_pulses(1);
    check_eq("cr_one_credit", 64'(credit_cnt), 64'd1);
    check_eq("cr_resume", 64'(in_consume), 64'b0001);
    tick();
    check_eq("cr_8th_flit", out_flit, mk(1, 1, 'h507));
    check_eq("cr_restall", 64'(in_consume), 64'd0);
    q[0].delete();
    drive();
    #1;
    credit_pulses(8);
    check_eq("cr_saturate", 64'(credit_cnt), 64'd7);

    // Asynchronous reset during flit 2 of a 4-flit packet on input 2
    push(2, mk(1, 0, 'h2a));
    push(2, mk(0, 0, 'h2b));
    push(2, mk(0, 0, 'h2c));
    push(2, mk(0, 1, 'h2d));
    tick();
    check_eq("ar_flit2_consume", 64'(in_consume), 64'b0100);
    rst = 1'b0;
    #1;
    check_eq("ar_produce", 64'(out_produce), 64'd0);
    check_eq("ar_flit", out_flit, 64'd0);
    check_eq("ar_credit", 64'(credit_cnt), 64'd7);
    check_eq("ar_consume", 64'(in_consume), 64'd0);
    tick();
    rst = 1'b1;
    // Leftover body flits on 2 plus a lone body flit on 0 are never granted
    push(0, mk(0, 0, 'h0b0));
    for (int k = 0; k < 3; k++) begin
      check_eq("body_consume", 64'(in_consume), 64'd0);
      tick();
      check_eq("body_produce", 64'(out_produce), 64'd0);
    end
    q[0].delete();
    q[2].delete();
    drive();
    #1;

    // Owner running dry in LOCKED stalls the port
    push(1, mk(1, 0, 'h1e));
    tick();
    push(3, mk(1, 1, 'h3e));
    push(0, mk(1, 1, 'h0e));
    check_eq("lk_empty_stall_a", 64'(in_consume), 64'd0);
    tick();
    check_eq("lk_empty_stall_b", 64'(in_consume), 64'd0);
    push(1, mk(0, 1, 'h1f));
    check_eq("lk_tail_consume", 64'(in_consume), 64'b0010);
    tick();
    check_eq("lk_wrap_consume", 64'(in_consume), 64'b1000);
    tick();
    check_eq("lk_next_consume", 64'(in_consume), 64'b0001);
    tick();
    check_eq("lk_last_flit", out_flit, mk(1, 1, 'h0e));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
